mod_mul_seq: RTL and testbench

- Multi-cycle modular multiplier. Computes OUT_MUL = (IN_1 * IN_2) mod IN_P for unsigned IP_WIDTH-bit operands.
- Companion to the combinational modular-inverse IP. It runs the forward direction: given x and x^-1 mod p, it must return 1, so benches use it to close the loop on the inverse IP.
- Stage 1 reduces IN_1 mod IN_P by serial restoring division.
- Stage 2 runs interleaved shift-add modular multiplication, MSB-first, one bit of IN_2 per cycle.

---
 rtl/mod_mul_seq_if.sv | 24 ++
 rtl/mod_mul_seq.sv | 127 ++++++++++++
 tb/tb_mod_mul_seq.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mod_mul_seq_if.sv
// Request/response bundle for the sequential modular multiplier.
// The master drives the operands; the slave (the multiplier) returns the result.
interface mod_mul_seq_if #(
    parameter int unsigned IP_WIDTH = 6
);
    logic                in_valid;
    logic [IP_WIDTH-1:0] IN_1;
    logic [IP_WIDTH-1:0] IN_2;
    logic [IP_WIDTH-1:0] IN_P;
    logic                busy;
    logic                out_valid;
    logic [IP_WIDTH-1:0] OUT_MUL;
    logic                OUT_ERR;

    modport master (
        output in_valid, IN_1, IN_2, IN_P,
        input  busy, out_valid, OUT_MUL, OUT_ERR
    );

    modport slave (
        input  in_valid, IN_1, IN_2, IN_P,
        output busy, out_valid, OUT_MUL, OUT_ERR
    );
endinterface

// File: rtl/mod_mul_seq.sv
// Multi-cycle (IN_1 * IN_2) mod IN_P: serial restoring reduction of IN_1,
// then MSB-first interleaved shift-add modular multiplication.
module mod_mul_seq #(
    parameter int unsigned IP_WIDTH = 6
) (
    input  logic          clk,
    input  logic          rst,
    mod_mul_seq_if.slave  bus
);
    localparam int unsigned W  = IP_WIDTH;
    localparam int unsigned CW = $clog2(IP_WIDTH);
    localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);

    typedef enum logic [1:0] {S_IDLE, S_REDUCE, S_MUL, S_DONE} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  p_q, p_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  a_red_q, a_red_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_mul_q, out_mul_d;
    logic          out_err_q, out_err_d;

    // W+1-bit intermediates; every reduced value is < p and so fits back in W bits
    logic [W:0] p_ext, t, t_red, d, d_red, s, s_red;
    logic       p_zero;

    always_comb begin
        p_ext  = {1'b0, p_q};
        p_zero = (p_q == '0);
        t      = {acc_q, a_q[cnt_q]};
        t_red  = (t >= p_ext) ? t - p_ext : t;
        d      = {acc_q, 1'b0};
        d_red  = (d >= p_ext) ? d - p_ext : d;
        s      = d_red + {1'b0, a_red_q};
        s_red  = (s >= p_ext) ? s - p_ext : s;
    end

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        p_d         = p_q;
        acc_d       = acc_q;
        a_red_d     = a_red_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.in_valid) begin
                    a_d     = bus.IN_1;
                    b_d     = bus.IN_2;
                    p_d     = bus.IN_P;
                    acc_d   = '0;
                    cnt_d   = CNT_TOP;
                    state_d = S_REDUCE;
                end
            end
            S_REDUCE: begin
                acc_d = p_zero ? '0 : W'(t_red);
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    a_red_d = p_zero ? '0 : W'(t_red);
                    acc_d   = '0;
                    cnt_d   = CNT_TOP;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (p_zero)          acc_d = '0;
                else if (b_q[cnt_q]) acc_d = W'(s_red);
                else                 acc_d = W'(d_red);
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // busy tracks the state being entered; the result strobe follows DONE by one edge
        busy_d      = (state_d == S_REDUCE) || (state_d == S_MUL);
        out_valid_d = (state_q == S_DONE);
        out_mul_d   = (state_q == S_DONE) ? acc_q : '0;
        out_err_d   = (state_q == S_DONE) && p_zero;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            p_q         <= '0;
            acc_q       <= '0;
            a_red_q     <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_mul_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            p_q         <= p_d;
            acc_q       <= acc_d;
            a_red_q     <= a_red_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_mul_q   <= out_mul_d;
            out_err_q   <= out_err_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.OUT_MUL   = out_mul_q;
    assign bus.OUT_ERR   = out_err_q;
endmodule

// File: tb/tb_mod_mul_seq.sv
// Directed self-checking bench for mod_mul_seq (W=6): latency, arithmetic,
// degenerate moduli, handshake rules and reset behaviour.
module tb_mod_mul_seq;
    localparam int unsigned W       = 6;
    localparam int unsigned LAT     = 2 * W + 1;
    localparam int unsigned MAX_LAT = 40;

    logic clk = 1'b0;
    logic rst;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    mod_mul_seq_if #(.IP_WIDTH(W)) bus ();

    mod_mul_seq #(.IP_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned inv_mod(input int unsigned x, input int unsigned p);
        for (int unsigned y = 1; y < p; y++)
            if ((x * y) % p == 1) return y;
        return 0;
    endfunction

    // Called at a negedge with the DUT ready; returns at the negedge showing out_valid.
    task automatic run_req(input int unsigned a, input int unsigned b, input int unsigned p,
                           output int unsigned res, output int unsigned err,
                           output int unsigned lat, output int unsigned vld);
        bus.in_valid = 1'b1;
        bus.IN_1     = W'(a);
        bus.IN_2     = W'(b);
        bus.IN_P     = W'(p);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < MAX_LAT) begin
            @(negedge clk);
            lat++;
        end
        vld = (bus.out_valid === 1'b1) ? 1 : 0;
        res = bus.OUT_MUL;
        err = bus.OUT_ERR;
    endtask

    int unsigned vec_a   [7] = '{5, 60, 5, 63, 63, 9, 37};
    int unsigned vec_b   [7] = '{7, 45, 8, 63, 63, 9, 50};
    int unsigned vec_p   [7] = '{13, 61, 13, 2, 63, 0, 1};
    int unsigned vec_res [7] = '{9, 16, 1, 1, 0, 0, 0};
    int unsigned vec_err [7] = '{0, 0, 0, 0, 0, 1, 0};

    initial begin
        int unsigned res, err, lat, vld, pulses;

        // Reset with garbage on the inputs
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.IN_1     = '0;
        bus.IN_2     = '0;
        bus.IN_P     = '0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'($urandom);
            bus.IN_1     = W'($urandom);
            bus.IN_2     = W'($urandom);
            bus.IN_P     = W'($urandom);
            @(negedge clk);
            check_eq("rst_busy", bus.busy, 0);
            check_eq("rst_out_valid", bus.out_valid, 0);
            check_eq("rst_out_mul", bus.OUT_MUL, 0);
            check_eq("rst_out_err", bus.OUT_ERR, 0);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_eq("post_rst_busy", bus.busy, 0);
        check_eq("post_rst_out_valid", bus.out_valid, 0);
        check_eq("post_rst_out_mul", bus.OUT_MUL, 0);
        check_eq("post_rst_out_err", bus.OUT_ERR, 0);

        // Directed vectors including degenerate moduli
        for (int i = 0; i < 7; i++) begin
            run_req(vec_a[i], vec_b[i], vec_p[i], res, err, lat, vld);
            check_eq($sformatf("vec%0d_valid", i), vld, 1);
            check_eq($sformatf("vec%0d_latency", i), lat, LAT);
            check_eq($sformatf("vec%0d_out_mul", i), res, vec_res[i]);
            check_eq($sformatf("vec%0d_out_err", i), err, vec_err[i]);
            @(negedge clk);
            check_eq($sformatf("vec%0d_strobe_len", i), bus.out_valid, 0);
        end

        // Inverse loopback over every nonzero residue mod 61
        for (int unsigned x = 1; x < 61; x++) begin
            run_req(x, inv_mod(x, 61), 61, res, err, lat, vld);
            check_eq($sformatf("inv61_x%0d", x), (vld == 1) ? res : 99, 1);
        end
        @(negedge clk);

        // Requests while busy are ignored
        bus.in_valid = 1'b1;
        bus.IN_1 = W'(5); bus.IN_2 = W'(7); bus.IN_P = W'(13);
        @(negedge clk);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < MAX_LAT) begin
            if (bus.busy === 1'b1) begin
                bus.in_valid = 1'b1;
                bus.IN_1 = W'($urandom);
                bus.IN_2 = W'($urandom);
                bus.IN_P = W'($urandom_range(2, 63));
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        check_eq("ign_latency", lat, LAT);
        check_eq("ign_out_mul", bus.OUT_MUL, 9);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1 || bus.busy === 1'b1) pulses++;
        end
        check_eq("ign_no_queue", pulses, 0);

        // Back-to-back: second request offered in the DONE cycle
        bus.in_valid = 1'b1;
        bus.IN_1 = W'(5); bus.IN_2 = W'(7); bus.IN_P = W'(13);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.busy === 1'b1 && lat < MAX_LAT) begin
            @(negedge clk);
            lat++;
        end
        check_eq("b2b_done_cycle", lat, LAT - 1);
        bus.in_valid = 1'b1;
        bus.IN_1 = W'(60); bus.IN_2 = W'(45); bus.IN_P = W'(61);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_eq("b2b_first_valid", bus.out_valid, 1);
        check_eq("b2b_first_out_mul", bus.OUT_MUL, 9);
        check_eq("b2b_second_busy", bus.busy, 1);
        lat = 0;
        while (bus.out_valid === 1'b1 && lat < MAX_LAT) begin
            @(negedge clk);
            lat++;
        end
        while (bus.out_valid !== 1'b1 && lat < MAX_LAT) begin
            @(negedge clk);
            lat++;
        end
        check_eq("b2b_second_latency", lat, LAT);
        check_eq("b2b_second_out_mul", bus.OUT_MUL, 16);
        @(negedge clk);

        // Reset in the third MUL cycle drops the request
        bus.in_valid = 1'b1;
        bus.IN_1 = W'(60); bus.IN_2 = W'(45); bus.IN_P = W'(61);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (W + 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1 || bus.busy === 1'b1) pulses++;
        end
        run_req(5, 7, 13, res, err, lat, vld);
        check_eq("midrst_dropped", pulses, 0);
        check_eq("midrst_valid", vld, 1);
        check_eq("midrst_latency", lat, LAT);
        check_eq("midrst_out_mul", res, 9);
        check_eq("midrst_out_err", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
